// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one external combinational 16-bit ALU between NUM_REQ requesters.
// Optional divide-by-zero flagging when ALU_ARB_DIVZERO_CHK_EN is defined.
module alu_req_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [16*NUM_REQ-1:0]  req_a,
  input  logic [16*NUM_REQ-1:0]  req_b,
  input  logic [4*NUM_REQ-1:0]   req_sel,
  output logic [15:0]            ALU_A,
  output logic [15:0]            ALU_B,
  output logic [3:0]             ALU_Sel,
  input  logic [15:0]            ALU_Out,
  input  logic                   CarryOut,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [15:0]            rsp_data,
  output logic                   rsp_carry,
  output logic                   rsp_err,
  output logic                   busy
);

  localparam int unsigned DW = 16;
  localparam int unsigned SW = 4;

  typedef struct packed {
    logic [SW-1:0] sel;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } op_t;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state, state_nxt;
  op_t               op_q;
  op_t               req_op [NUM_REQ];
  logic [ID_W-1:0]   last_grant, grant;
  logic              any_valid;
  int unsigned       rr_idx;
  logic [NUM_REQ-1:0] ready_raw;
  logic [DW-1:0]     cap_data;
  logic              cap_err;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_op[i].sel = req_sel[SW*i +: SW];
    assign req_op[i].a   = req_a[DW*i +: DW];
    assign req_op[i].b   = req_b[DW*i +: DW];
  end

  // Round-robin search starting one past the previous winner.
  always_comb begin
    grant     = last_grant;
    any_valid = 1'b0;
    rr_idx    = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      rr_idx = (32'(last_grant) + i) % NUM_REQ;
      if (!any_valid && req_valid[ID_W'(rr_idx)]) begin
        any_valid = 1'b1;
        grant     = ID_W'(rr_idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready_raw = '0;
    case (state)
      IDLE: if (any_valid) begin
        ready_raw[grant] = 1'b1;
        state_nxt        = EXEC;
      end
      EXEC: state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Held in reset, no requester may believe it was accepted.
  assign req_ready = ready_raw & {NUM_REQ{rst_n}};

  always_comb begin
`ifdef ALU_ARB_DIVZERO_CHK_EN
    cap_err  = (op_q.sel == 4'b0011) && (op_q.b == '0);
    cap_data = cap_err ? 16'hFFFF : ALU_Out;
`else
    cap_err  = 1'b0;
    cap_data = ALU_Out;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
      rsp_id     <= '0;
      rsp_data   <= '0;
      rsp_carry  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rsp_valid <= (state_nxt == RESP);
      busy      <= (state_nxt != IDLE);
      if (state == IDLE && any_valid) begin
        op_q       <= req_op[grant];
        rsp_id     <= grant;
        last_grant <= grant;
      end
      if (state == EXEC) begin
        rsp_data  <= cap_data;
        rsp_carry <= CarryOut;
        rsp_err   <= cap_err;
      end
    end
  end

  assign ALU_A   = op_q.a;
  assign ALU_B   = op_q.b;
  assign ALU_Sel = op_q.sel;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: behavioural ALU plus transaction-level arbitration model.
module tb_alu_req_arbiter;
  localparam int unsigned N = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_ready;
  logic [16*N-1:0] req_a, req_b;
  logic [4*N-1:0]  req_sel;
  logic [15:0]     ALU_A, ALU_B, ALU_Out;
  logic [3:0]      ALU_Sel;
  logic            CarryOut;
  logic            rsp_valid, rsp_ready, rsp_carry, rsp_err, busy;
  logic [1:0]      rsp_id;
  logic [15:0]     rsp_data;

  int total = 0;
  int bad   = 0;
  int mlast = N - 1;
  logic [15:0] ta [N];
  logic [15:0] tb_ [N];
  logic [3:0]  ts [N];

  alu_req_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_Sel(ALU_Sel), .ALU_Out(ALU_Out), .CarryOut(CarryOut),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_carry(rsp_carry), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] alu_f(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s);
    case (s)
      4'd0:    return {1'b0, a} + {1'b0, b};
      4'd1:    return {1'b0, a} - {1'b0, b};
      4'd2:    return {1'b0, 16'(a * b)};
      4'd3:    return (b == 16'h0) ? 17'h0 : {1'b0, 16'(a / b)};
      4'd4:    return {1'b0, a & b};
      4'd5:    return {1'b0, a | b};
      4'd6:    return {1'b0, a ^ b};
      4'd7:    return {a, 1'b0};
      default: return {s[0], a ^ ~b};
    endcase
  endfunction

  always_comb {CarryOut, ALU_Out} = alu_f(ALU_A, ALU_B, ALU_Sel);

  function automatic int pick(input logic [N-1:0] mask, input int last);
    for (int i = 1; i <= int'(N); i++)
      if (mask[(last + i) % N]) return (last + i) % N;
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(req_ready), 0);
    check({tag, "_rvalid"}, 32'(rsp_valid), 0);
    check({tag, "_id"}, 32'(rsp_id), 0);
    check({tag, "_data"}, 32'(rsp_data), 0);
    check({tag, "_carry"}, 32'(rsp_carry), 0);
    check({tag, "_err"}, 32'(rsp_err), 0);
    check({tag, "_alu"}, {ALU_Sel, ALU_A, 12'h0}, 0);
    check({tag, "_aluB"}, 32'(ALU_B), 0);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic drive_ops();
    for (int i = 0; i < int'(N); i++) begin
      req_a[16*i +: 16] = ta[i];
      req_b[16*i +: 16] = tb_[i];
      req_sel[4*i +: 4] = ts[i];
    end
  endtask

  // One full transaction starting in an IDLE cycle, just after a rising edge.
  task automatic run_op(input logic [N-1:0] mask, input int stall);
    int g;
    logic [16:0] r;
    logic [15:0] ed;
    logic ee;
    g  = pick(mask, mlast);
    r  = alu_f(ta[g], tb_[g], ts[g]);
    ed = r[15:0];
    ee = 1'b0;
`ifdef ALU_ARB_DIVZERO_CHK_EN
    if (ts[g] == 4'b0011 && tb_[g] == 16'h0) begin ed = 16'hFFFF; ee = 1'b1; end
`endif
    req_valid = mask;
    drive_ops();
    rsp_ready = (stall == 0);
    #1;
    check("grant_ready", 32'(req_ready), 32'(1) << g);
    check("idle_busy", 32'(busy), 0);
    @(posedge clk); #1;
    mlast = g;
    check("exec_ready", 32'(req_ready), 0);
    check("exec_busy", 32'(busy), 1);
    check("exec_rvalid", 32'(rsp_valid), 0);
    check("alu_a", 32'(ALU_A), 32'(ta[g]));
    check("alu_b", 32'(ALU_B), 32'(tb_[g]));
    check("alu_sel", 32'(ALU_Sel), 32'(ts[g]));
    @(posedge clk); #1;
    check("rsp_valid", 32'(rsp_valid), 1);
    check("rsp_id", 32'(rsp_id), 32'(g));
    check("rsp_data", 32'(rsp_data), 32'(ed));
    check("rsp_carry", 32'(rsp_carry), 32'(r[16]));
    check("rsp_err", 32'(rsp_err), 32'(ee));
    check("resp_ready", 32'(req_ready), 0);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check("stall_valid", 32'(rsp_valid), 1);
      check("stall_data", 32'(rsp_data), 32'(ed));
      check("stall_id", 32'(rsp_id), 32'(g));
      check("stall_ready", 32'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("back_idle_valid", 32'(rsp_valid), 0);
    check("back_idle_busy", 32'(busy), 0);
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b, input logic [3:0] s);
    ta[i] = a; tb_[i] = b; ts[i] = s;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_sel = '0;
    for (int i = 0; i < int'(N); i++) set_op(i, 16'(i), 16'(i + 1), 4'(i));
    #12;
    check_all_zero("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // No request: nothing granted, stays idle.
    req_valid = '0; #1;
    check("noreq_ready", 32'(req_ready), 0);
    @(posedge clk); #1;
    check("noreq_busy", 32'(busy), 0);

    set_op(2, 16'h0003, 16'h0004, 4'b0000);
    run_op(4'b0100, 0);

    // All requesters held valid: rotating grants.
    for (int i = 0; i < int'(N); i++) set_op(i, 16'(16'h100 * (i + 1)), 16'(i), 4'b0000);
    for (int k = 0; k < 5; k++) run_op(4'b1111, 0);

    set_op(1, 16'hFFFF, 16'h0001, 4'b0000);
    run_op(4'b0010, 0);

    set_op(3, 16'h1234, 16'h0F0F, 4'b0110);
    run_op(4'b1111, 5);

    set_op(0, 16'h0010, 16'h0000, 4'b0011);
    run_op(4'b0001, 0);

    // Reset during EXEC discards the operation.
    set_op(2, 16'hAAAA, 16'h5555, 4'b0001);
    req_valid = 4'b0100; drive_ops(); rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("pre_rst_busy", 32'(busy), 1);
    rst_n = 1'b0; req_valid = 4'b1010; #1;
    check_all_zero("midrst");
    req_valid = '0;
    @(negedge clk); rst_n = 1'b1; mlast = N - 1;
    @(posedge clk); #1;
    check("post_rst_rvalid", 32'(rsp_valid), 0);
    check("post_rst_busy", 32'(busy), 0);
    set_op(1, 16'h0007, 16'h0002, 4'b0010);
    set_op(3, 16'h0001, 16'h0001, 4'b0000);
    run_op(4'b1010, 0);

    // Randomized traffic.
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < int'(N); i++)
        set_op(i, 16'($urandom), ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom),
               4'($urandom_range(0, 15)));
      run_op(4'($urandom_range(1, 15)), int'($urandom_range(0, 3)));
    end

    req_valid = '0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
